// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: funct codes,
// FSM state encoding and the default operand width.
package muldiv_ctrl_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // True for the eight funct codes that touch the HI/LO resource.
  function automatic logic is_hilo_op(input logic [5:0] f);
    return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> mul/div unit bundle; master is the pipeline, slave the unit.
interface muldiv_ctrl_if
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             Issue_IN;
  logic [5:0]       Funct_IN;
  logic [WIDTH-1:0] Rs_Val_IN;
  logic [WIDTH-1:0] Rt_Val_IN;
  logic             Stall_OUT;
  logic             Busy_OUT;
  logic             Done_OUT;
  logic [WIDTH-1:0] HI_OUT;
  logic [WIDTH-1:0] LO_OUT;

  modport master (
    output Issue_IN, Funct_IN, Rs_Val_IN, Rt_Val_IN,
    input  Stall_OUT, Busy_OUT, Done_OUT, HI_OUT, LO_OUT
  );

  modport slave (
    input  Issue_IN, Funct_IN, Rs_Val_IN, Rt_Val_IN,
    output Stall_OUT, Busy_OUT, Done_OUT, HI_OUT, LO_OUT
  );
endinterface

// File: rtl/muldiv_ctrl_iter_step.sv
// One radix-2 iteration on unsigned magnitudes: LSB-first shift-add multiply
// or restoring divide, selected by i_div.
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_opb,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  always_comb begin
    // Multiply: {carry,acc,q} shifts right, product builds in {acc,q}.
    w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_opb} : {(WIDTH+1){1'b0}});
    // Divide: remainder < divisor, so a clear MSB of the difference means no borrow.
    w_shift = {i_acc, i_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_opb};
    o_acc   = w_sum[WIDTH:1];
    o_q     = {w_sum[0], i_q[WIDTH-1:1]};
    if (i_div) begin
      if (!w_diff[WIDTH]) begin
        o_acc = w_diff[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = w_shift[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: accepts MULT/DIV/MTxx/MFxx from EX,
// iterates WIDTH steps on magnitudes, sign-fixes and writes HI/LO.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int    comment = 0,
  parameter string name    = "??",
  parameter int    WIDTH   = WIDTH_DEF
) (
  input  logic           CLK,
  input  logic           RESET,
  muldiv_ctrl_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_acc, r_q, r_opb, r_opa;
  logic             r_sa, r_sb, r_dz, r_is_div, r_done;

  logic             w_busy, w_known, w_accept, w_signed;
  logic             w_rs_neg, w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag, w_rt_mag;
  logic [WIDTH-1:0] w_acc_n, w_q_n;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo, w_rem, w_hi_n, w_lo_n;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_known   = is_hilo_op(bus.Funct_IN);
  assign w_accept  = bus.Issue_IN & w_known & ~w_busy;
  assign w_signed  = (bus.Funct_IN == FN_MULT) || (bus.Funct_IN == FN_DIV);
  assign w_rs_neg  = w_signed & bus.Rs_Val_IN[WIDTH-1];
  assign w_rt_neg  = w_signed & bus.Rt_Val_IN[WIDTH-1];
  assign w_rs_mag  = w_rs_neg ? (~bus.Rs_Val_IN + 1'b1) : bus.Rs_Val_IN;
  assign w_rt_mag  = w_rt_neg ? (~bus.Rt_Val_IN + 1'b1) : bus.Rt_Val_IN;

  assign bus.Stall_OUT = bus.Issue_IN & w_known & w_busy;
  assign bus.Busy_OUT  = w_busy;
  assign bus.Done_OUT  = r_done;
  assign bus.HI_OUT    = r_hi;
  assign bus.LO_OUT    = r_lo;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_div (r_is_div),
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_opb (r_opb),
    .o_acc (w_acc_n),
    .o_q   (w_q_n)
  );

  // Sign correction of the magnitude results; the 0x80..0/-1 case falls out
  // naturally because negating 0x80..0 yields itself.
  always_comb begin
    w_prod = {r_acc, r_q};
    if (r_sa ^ r_sb) w_prod = ~w_prod + 1'b1;
    w_quo  = (r_sa ^ r_sb) ? (~r_q + 1'b1) : r_q;
    w_rem  = r_sa ? (~r_acc + 1'b1) : r_acc;
    if (r_dz) begin
      w_quo = '1;
      w_rem = r_opa;
    end
    w_hi_n = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    w_lo_n = r_is_div ? w_quo : w_prod[WIDTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opb    <= '0;
      r_opa    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dz     <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (bus.Funct_IN)
              FN_MULT, FN_MULTU: begin
                r_state  <= ST_MUL;
                r_is_div <= 1'b0;
                r_acc    <= '0;
                r_q      <= w_rt_mag;
                r_opb    <= w_rs_mag;
                r_opa    <= bus.Rs_Val_IN;
                r_sa     <= w_rs_neg;
                r_sb     <= w_rt_neg;
                r_dz     <= 1'b0;
                r_cnt    <= '0;
              end
              FN_DIV, FN_DIVU: begin
                r_state  <= ST_DIV;
                r_is_div <= 1'b1;
                r_acc    <= '0;
                r_q      <= w_rs_mag;
                r_opb    <= w_rt_mag;
                r_opa    <= bus.Rs_Val_IN;
                r_sa     <= w_rs_neg;
                r_sb     <= w_rt_neg;
                r_dz     <= (bus.Rt_Val_IN == '0);
                r_cnt    <= '0;
              end
              FN_MTHI: r_hi <= bus.Rs_Val_IN;
              FN_MTLO: r_lo <= bus.Rs_Val_IN;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_hi    <= w_hi_n;
          r_lo    <= w_lo_n;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  generate
    if (comment != 0) begin : g_trace
      always @(posedge CLK) begin
        if (!RESET && w_accept) begin
          case (bus.Funct_IN)
            FN_MULT:  $write("[%s]mult\n", name);
            FN_MULTU: $write("[%s]multu\n", name);
            FN_DIV:   $write("[%s]div\n", name);
            FN_DIVU:  $write("[%s]divu\n", name);
            FN_MFHI:  $write("[%s]mfhi\n", name);
            FN_MTHI:  $write("[%s]mthi\n", name);
            FN_MFLO:  $write("[%s]mflo\n", name);
            default:  $write("[%s]mtlo\n", name);
          endcase
        end
        if (!RESET && r_state == ST_FIX)
          $write("[%s]done HI=%h LO=%h\n", name, w_hi_n, w_lo_n);
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;
  logic [31:0] mhi, mlo;

  always #5 clk = ~clk;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.comment(0), .name("md0"), .WIDTH(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = 32'h0; l = 32'h0;
    case (f)
      FN_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      FN_MULTU: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
      FN_DIV: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      FN_DIVU: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin h = a % b; l = a / b; end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1 with the unit idle; leaves at posedge+1 after HI/LO update.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int n;
    logic early;
    model(f, a, b, eh, el);
    bus.Issue_IN = 1'b1; bus.Funct_IN = f; bus.Rs_Val_IN = a; bus.Rt_Val_IN = b;
    #1 chk({tag, "_stall_idle"}, 64'(bus.Stall_OUT), 64'd0);
    @(posedge clk); #1;
    bus.Issue_IN = 1'b0;
    n = 0; early = 1'b0;
    while (bus.Busy_OUT && n < 100) begin
      if (bus.Done_OUT) early = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
    chk({tag, "_done_early"}, 64'(early), 64'd0);
    chk({tag, "_done"}, 64'(bus.Done_OUT), 64'd1);
    chk({tag, "_hi"}, 64'(bus.HI_OUT), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.LO_OUT), 64'(el));
    mhi = eh; mlo = el;
  endtask

  task automatic move_op(input string tag, input logic [5:0] f, input logic [31:0] a);
    bus.Issue_IN = 1'b1; bus.Funct_IN = f; bus.Rs_Val_IN = a; bus.Rt_Val_IN = $urandom;
    #1 chk({tag, "_stall"}, 64'(bus.Stall_OUT), 64'd0);
    @(posedge clk); #1;
    bus.Issue_IN = 1'b0;
    if (f == FN_MTHI) mhi = a;
    if (f == FN_MTLO) mlo = a;
    chk({tag, "_hi"}, 64'(bus.HI_OUT), 64'(mhi));
    chk({tag, "_lo"}, 64'(bus.LO_OUT), 64'(mlo));
    chk({tag, "_busy"}, 64'(bus.Busy_OUT), 64'd0);
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] a, b, eh, el;
    logic [5:0] fs [6];
    fs = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO};

    rst = 1'b1;
    bus.Issue_IN = 1'b0; bus.Funct_IN = 6'h0; bus.Rs_Val_IN = '0; bus.Rt_Val_IN = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.Busy_OUT), 64'd0);
    chk("rst_done", 64'(bus.Done_OUT), 64'd0);
    chk("rst_hi", 64'(bus.HI_OUT), 64'd0);
    chk("rst_lo", 64'(bus.LO_OUT), 64'd0);
    rst = 1'b0;
    mhi = 0; mlo = 0;

    run_op("mult_m4", FN_MULT, 32'd3, 32'hFFFF_FFFC);
    chk("mult_m4_hi_k", 64'(bus.HI_OUT), 64'h0000_0000_FFFF_FFFF);
    chk("mult_m4_lo_k", 64'(bus.LO_OUT), 64'h0000_0000_FFFF_FFF4);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(bus.Done_OUT), 64'd0);

    run_op("multu_ff", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_ff_hi_k", 64'(bus.HI_OUT), 64'h0000_0000_FFFF_FFFE);
    chk("multu_ff_lo_k", 64'(bus.LO_OUT), 64'h0000_0000_0000_0001);
    // Back-to-back: next op issued in the first cycle after the update edge.
    run_op("div_m7", FN_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_lo_k", 64'(bus.LO_OUT), 64'h0000_0000_FFFF_FFFD);
    chk("div_m7_hi_k", 64'(bus.HI_OUT), 64'h0000_0000_FFFF_FFFF);
    run_op("divu_z", FN_DIVU, 32'h1234, 32'h0);
    chk("divu_z_lo_k", 64'(bus.LO_OUT), 64'h0000_0000_FFFF_FFFF);
    chk("divu_z_hi_k", 64'(bus.HI_OUT), 64'h0000_0000_0000_1234);
    run_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_k", 64'(bus.LO_OUT), 64'h0000_0000_8000_0000);
    chk("div_ovf_hi_k", 64'(bus.HI_OUT), 64'h0);
    run_op("div_sz", FN_DIV, 32'hFFFF_FF00, 32'h0);

    // mflo behind an in-flight mult stalls through the FIX cycle.
    a = 32'h0001_2345; b = 32'hFFFF_0003;
    model(FN_MULT, a, b, eh, el);
    bus.Issue_IN = 1'b1; bus.Funct_IN = FN_MULT; bus.Rs_Val_IN = a; bus.Rt_Val_IN = b;
    @(posedge clk); #1;
    bus.Issue_IN = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.Issue_IN = 1'b1; bus.Funct_IN = FN_MFLO;
    #1;
    n = 0;
    while (bus.Stall_OUT && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("mflo_stall_cycles", 64'(n), 64'd28);
    chk("mflo_lo_new", 64'(bus.LO_OUT), 64'(el));
    chk("mflo_done", 64'(bus.Done_OUT), 64'd1);
    mhi = eh; mlo = el;
    @(posedge clk); #1;
    bus.Issue_IN = 1'b0;
    chk("mflo_no_busy", 64'(bus.Busy_OUT), 64'd0);
    chk("mflo_lo_hold", 64'(bus.LO_OUT), 64'(mlo));

    // Unrelated funct never stalls; a blocked mthi must not write HI.
    a = 32'd77; b = 32'd5;
    model(FN_DIVU, a, b, eh, el);
    bus.Issue_IN = 1'b1; bus.Funct_IN = FN_DIVU; bus.Rs_Val_IN = a; bus.Rt_Val_IN = b;
    @(posedge clk); #1;
    bus.Issue_IN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.Issue_IN = 1'b1; bus.Funct_IN = 6'b100000; bus.Rs_Val_IN = 32'hDEAD_BEEF;
    #1 chk("add_no_stall", 64'(bus.Stall_OUT), 64'd0);
    chk("add_busy", 64'(bus.Busy_OUT), 64'd1);
    bus.Funct_IN = FN_MTHI;
    #1 chk("mthi_busy_stall", 64'(bus.Stall_OUT), 64'd1);
    @(posedge clk); #1;
    bus.Issue_IN = 1'b0;
    n = 0;
    while (bus.Busy_OUT && n < 100) begin n++; @(posedge clk); #1; end
    chk("divu_hi_no_mthi", 64'(bus.HI_OUT), 64'(eh));
    chk("divu_lo", 64'(bus.LO_OUT), 64'(el));
    mhi = eh; mlo = el;

    // Reset mid-divide discards the op.
    bus.Issue_IN = 1'b1; bus.Funct_IN = FN_DIV; bus.Rs_Val_IN = 32'd1000; bus.Rt_Val_IN = 32'd7;
    @(posedge clk); #1;
    bus.Issue_IN = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 64'(bus.Busy_OUT), 64'd0);
    chk("mid_rst_hi", 64'(bus.HI_OUT), 64'd0);
    chk("mid_rst_lo", 64'(bus.LO_OUT), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done_OUT) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_done", 64'(seen), 64'd0);
    mhi = 0; mlo = 0;
    move_op("mthi_a5", FN_MTHI, 32'hA5A5_A5A5);

    // Randomized mix.
    for (int i = 0; i < 24; i++) begin
      int k;
      k = int'($urandom_range(0, 5));
      if (k < 4) run_op($sformatf("rnd%0d", i), fs[k], pick(), pick());
      else move_op($sformatf("rnd%0d", i), fs[k], $urandom);
    end
    move_op("mfhi_idle", FN_MFHI, 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the HI/LO multiply/divide resource used by MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO and MTLO.
- Accepts one op per issue from the EX stage and runs an iterative radix-2 shift-add multiply or restoring divide.
- Owns the HI/LO registers.
- Generates the pipeline stall when a HI/LO consumer or a new mul/div arrives while the unit is busy.

Parameters:
comment, 0, nonzero enables per-op $write trace (simulation only, no effect on behaviour)
name, "??", tag printed in trace lines
WIDTH, 32, operand width; iteration count equals WIDTH

Ports:
CLK  input  1  clock
RESET  input  1  synchronous, active-high reset
Issue_IN  input  1  EX stage presents a SPECIAL instruction this cycle
Funct_IN  input  6  funct field of the issued instruction
Rs_Val_IN  input  WIDTH  rs operand (dividend/multiplicand, MTHI/MTLO source)
Rt_Val_IN  input  WIDTH  rt operand (divisor/multiplier)
Stall_OUT  output  1  combinational; hold EX and earlier stages
Busy_OUT  output  1  iteration in progress
Done_OUT  output  1  one-cycle pulse in the cycle HI/LO take a mul/div result
HI_OUT  output  WIDTH  HI register
LO_OUT  output  WIDTH  LO register

Behaviour:
- Reset: takes effect on any CLK edge with RESET=1, including mid-operation. Forces state IDLE, count=0, HI=LO=0, Busy=0, Done=0. Any op in flight is discarded with no HI/LO write.
- Recognised funct codes:
  - 011000 mult, 011001 multu, 011010 div, 011011 divu
  - 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo
  - Any other funct is ignored and never stalls.
- Stall_OUT = Issue_IN & (funct is one of the 8 recognised codes) & Busy_OUT.
- An op is accepted only on an edge where Issue_IN=1 and Stall_OUT=0.
- States:
  - IDLE: accept mult/multu -> MUL; div/divu -> DIV. On entry, latch operand magnitudes and sign flags (signed ops only), and set count=0.
  - MUL: one shift-add step per cycle. Count increments each cycle; at count=WIDTH-1 -> FIX.
  - DIV: one restoring subtract/shift step per cycle. Same count rule as MUL -> FIX.
  - FIX: apply sign correction, write HI/LO, pulse Done_OUT, -> IDLE.
- Latency:
  - Accept at edge E0; Busy_OUT=1 from after E0 through E33; HI/LO updated at E33.
  - Busy is therefore high for WIDTH+1 cycles.
  - A new mul/div may be accepted in the first cycle after E33.
- mthi/mtlo when not busy: HI (or LO) <= Rs_Val_IN at the accept edge. No state change.
- mfhi/mflo when not busy: no state change. The pipeline reads HI_OUT/LO_OUT directly.
- Results:
  - mult/multu: {HI,LO} = 2*WIDTH-bit product; signed for mult, unsigned for multu.
  - div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide-by-zero (Rt=0): LO = all ones, HI = Rs_Val. No exception.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- Simultaneous events:
  - Issue in the FIX cycle stalls (Busy still 1).
  - An mfhi issued the cycle after E33 sees the new HI.
- Trace: when comment != 0, print "[name]op" on accept and "[name]done HI=%h LO=%h" on FIX.

Decomposition:
- Shared package holds:
  - funct constants (FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO);
  - the state encoding (IDLE, MUL, DIV, FIX);
  - the WIDTH default.
- Sub-module muldiv_iter_step, combinational: given the partial accumulator, remainder and operand registers plus a mode bit, it returns the next-step values.
- The controller keeps the FSM, counter, sign flags, HI/LO and stall logic.

Test Plan:
- mult Rs=3, Rt=0xFFFFFFFC (-4) -> Busy 33 cycles, Done pulse at E33; HI=FFFFFFFF, LO=FFFFFFF4.
- multu Rs=Rt=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
- div Rs=0xFFFFFFF9 (-7), Rt=2 -> LO=FFFFFFFD (-3), HI=FFFFFFFF (-1).
- divu Rs=0x1234, Rt=0 -> LO=FFFFFFFF, HI=00001234.
- mult accepted, then mflo issued 5 cycles later -> Stall_OUT=1 until Busy drops; mflo accepted the cycle after E33 with LO holding the new product. An add (funct 100000) issued while busy -> Stall_OUT=0.
- div in flight, RESET pulsed at count=10 -> HI=LO=0, Busy=0, Done never pulses. A subsequent mthi 0xA5A5A5A5 -> HI=A5A5A5A5 next edge.
